// File: rtl/wb_master_port.sv
// Single-outstanding Wishbone pipelined master: one client request -> one bus cycle -> one response strobe.
// States: IDLE (bus free, ready) | REQUEST (STB up, waiting out STALL) | WAIT_ACK (STB down, waiting ACK/ERR/timeout).
module wb_master_port #(
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned TW      = 16
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_we,
  input  logic [29:0] i_req_addr,
  input  logic [31:0] i_req_data,
  input  logic [3:0]  i_req_sel,
  output logic        o_resp_valid,
  output logic [31:0] o_resp_data,
  output logic        o_resp_err,
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  output logic        o_wb_we,
  output logic [29:0] o_wb_addr,
  output logic [31:0] o_wb_data,
  output logic [3:0]  o_wb_sel,
  input  logic        i_wb_ack,
  input  logic        i_wb_stall,
  input  logic [31:0] i_wb_data,
  input  logic        i_wb_err
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_REQUEST  = 2'd1,
    S_WAIT_ACK = 2'd2
  } state_t;

  localparam bit            TO_EN   = (TIMEOUT != 0);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  state_t        state_q, state_d;
  logic          cyc_q, cyc_d;
  logic          stb_q, stb_d;
  logic          we_q, we_d;
  logic [29:0]   addr_q, addr_d;
  logic [31:0]   data_q, data_d;
  logic [3:0]    sel_q, sel_d;
  logic          resp_valid_q, resp_valid_d;
  logic [31:0]   resp_data_q, resp_data_d;
  logic          resp_err_q, resp_err_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic          timeout_hit;

  assign timeout_hit = TO_EN && (cnt_q == TO_LAST);

  always_comb begin
    state_d      = state_q;
    cyc_d        = cyc_q;
    stb_d        = stb_q;
    we_d         = we_q;
    addr_d       = addr_q;
    data_d       = data_q;
    sel_d        = sel_q;
    resp_valid_d = 1'b0;
    resp_data_d  = resp_data_q;
    resp_err_d   = resp_err_q;
    cnt_d        = cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (i_req_valid) begin
          state_d = S_REQUEST;
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          we_d    = i_req_we;
          addr_d  = i_req_addr;
          data_d  = i_req_data;
          sel_d   = i_req_sel;
          cnt_d   = '0;
        end
      end

      S_REQUEST: begin
        cnt_d = cnt_q + TW'(1);
        // ACK/ERR here belong to nobody: nothing has been accepted by the slave yet.
        if (timeout_hit) begin
          state_d      = S_IDLE;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
          resp_data_d  = '0;
        end else if (!i_wb_stall) begin
          state_d = S_WAIT_ACK;
          stb_d   = 1'b0;
        end
      end

      S_WAIT_ACK: begin
        cnt_d = cnt_q + TW'(1);
        if (i_wb_err) begin
          state_d      = S_IDLE;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
          resp_data_d  = '0;
        end else if (i_wb_ack) begin
          state_d      = S_IDLE;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b0;
          resp_data_d  = we_q ? 32'h0 : i_wb_data;
        end else if (timeout_hit) begin
          state_d      = S_IDLE;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
          resp_data_d  = '0;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Every exit to IDLE releases the bus and parks the address/data lines at zero.
    if (state_q != S_IDLE && state_d == S_IDLE) begin
      cyc_d  = 1'b0;
      stb_d  = 1'b0;
      we_d   = 1'b0;
      addr_d = '0;
      data_d = '0;
      sel_d  = '0;
      cnt_d  = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q      <= S_IDLE;
      cyc_q        <= 1'b0;
      stb_q        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      sel_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_err_q   <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      cyc_q        <= cyc_d;
      stb_q        <= stb_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      sel_q        <= sel_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_err_q   <= resp_err_d;
      cnt_q        <= cnt_d;
    end
  end

  assign o_req_ready  = (state_q == S_IDLE);
  assign o_resp_valid = resp_valid_q;
  assign o_resp_data  = resp_data_q;
  assign o_resp_err   = resp_err_q;
  assign o_wb_cyc     = cyc_q;
  assign o_wb_stb     = stb_q;
  assign o_wb_we      = we_q;
  assign o_wb_addr    = addr_q;
  assign o_wb_data    = data_q;
  assign o_wb_sel     = sel_q;

endmodule

// File: tb/tb_wb_master_port.sv
// Self-checking bench for wb_master_port: directed and random transactions against a slave-plan reference model.
module tb_wb_master_port;

  localparam int TO = 8;

  logic        clk_sys = 1'b0;
  logic        i_reset;
  logic        i_req_valid;
  logic        o_req_ready;
  logic        i_req_we;
  logic [29:0] i_req_addr;
  logic [31:0] i_req_data;
  logic [3:0]  i_req_sel;
  logic        o_resp_valid;
  logic [31:0] o_resp_data;
  logic        o_resp_err;
  logic        o_wb_cyc;
  logic        o_wb_stb;
  logic        o_wb_we;
  logic [29:0] o_wb_addr;
  logic [31:0] o_wb_data;
  logic [3:0]  o_wb_sel;
  logic        i_wb_ack;
  logic        i_wb_stall;
  logic [31:0] i_wb_data;
  logic        i_wb_err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_sys = ~clk_sys;

  wb_master_port #(.TIMEOUT(TO), .TW(16)) dut (
    .i_clk       (clk_sys),
    .i_reset     (i_reset),
    .i_req_valid (i_req_valid),
    .o_req_ready (o_req_ready),
    .i_req_we    (i_req_we),
    .i_req_addr  (i_req_addr),
    .i_req_data  (i_req_data),
    .i_req_sel   (i_req_sel),
    .o_resp_valid(o_resp_valid),
    .o_resp_data (o_resp_data),
    .o_resp_err  (o_resp_err),
    .o_wb_cyc    (o_wb_cyc),
    .o_wb_stb    (o_wb_stb),
    .o_wb_we     (o_wb_we),
    .o_wb_addr   (o_wb_addr),
    .o_wb_data   (o_wb_data),
    .o_wb_sel    (o_wb_sel),
    .i_wb_ack    (i_wb_ack),
    .i_wb_stall  (i_wb_stall),
    .i_wb_data   (i_wb_data),
    .i_wb_err    (i_wb_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic slave_idle();
    i_wb_ack   = 1'b0;
    i_wb_err   = 1'b0;
    i_wb_stall = 1'b0;
    i_wb_data  = $urandom;
  endtask

  // Slave plan: stall s cycles, then accept; answer w cycles after acceptance (w large = never).
  // Expected outcome from the rules: CYC lasts s+1+w cycles unless that exceeds TO, where it is cut at TO with err.
  // Entered and left at a negedge.
  task automatic run_txn(input bit we, input logic [29:0] addr, input logic [31:0] wdata,
                         input logic [3:0] sel, input int s, input int w, input bit is_err,
                         input bit err_with_ack, input bit spurious, input logic [31:0] rdata);
    int          c, cyc_n, stb_n, resp_n, k;
    bit          done, bus_ok, rdy_ok;
    int          exp_cyc, exp_stb;
    bit          exp_err;
    logic [31:0] exp_data, held_data;
    logic        held_err;

    if (s + 1 + w <= TO) begin
      exp_cyc  = s + 1 + w;
      exp_err  = is_err;
      exp_data = (is_err || we) ? 32'h0 : rdata;
    end else begin
      exp_cyc  = TO;
      exp_err  = 1'b1;
      exp_data = 32'h0;
    end
    exp_stb = (s + 1 < TO) ? s + 1 : TO;

    k = 0;
    while (!o_req_ready && k < 50) begin
      @(negedge clk_sys);
      k++;
    end
    chk("ready_before_req", {31'h0, o_req_ready}, 32'h1);

    i_req_valid = 1'b1;
    i_req_we    = we;
    i_req_addr  = addr;
    i_req_data  = wdata;
    i_req_sel   = sel;
    @(negedge clk_sys);
    i_req_valid = 1'b0;
    i_req_we    = $urandom_range(0, 1);
    i_req_addr  = 30'($urandom);
    i_req_data  = $urandom;
    i_req_sel   = 4'($urandom);

    c = 1; cyc_n = 0; stb_n = 0; resp_n = 0; done = 0; bus_ok = 1; rdy_ok = 1;
    while (!done && c < 60) begin
      if (o_wb_cyc) begin
        cyc_n++;
        if (o_wb_stb) stb_n++;
        if (o_wb_addr !== addr || o_wb_we !== we || o_wb_sel !== sel || o_wb_data !== wdata) bus_ok = 0;
        if (o_resp_valid) resp_n++;
        if (o_req_ready) rdy_ok = 0;
        i_wb_stall = (c <= s);
        i_wb_ack   = (c == 1 && spurious) || (c == s + 1 + w && (!is_err || err_with_ack));
        i_wb_err   = (c == s + 1 + w) && is_err;
        i_wb_data  = (c == s + 1 + w) ? rdata : $urandom;
        @(negedge clk_sys);
        c++;
      end else begin
        done = 1;
      end
    end
    slave_idle();

    chk("cyc_released", {31'h0, done}, 32'h1);
    chk("cyc_cycles", cyc_n, exp_cyc);
    chk("stb_cycles", stb_n, exp_stb);
    chk("bus_stable", {31'h0, bus_ok}, 32'h1);
    chk("ready_low_busy", {31'h0, rdy_ok}, 32'h1);
    chk("resp_early", resp_n, 0);
    chk("resp_valid", {31'h0, o_resp_valid}, 32'h1);
    chk("resp_err", {31'h0, o_resp_err}, {31'h0, exp_err});
    chk("resp_data", o_resp_data, exp_data);
    chk("ready_at_resp", {31'h0, o_req_ready}, 32'h1);
    chk("wb_addr_parked", {2'b0, o_wb_addr}, 32'h0);
    held_data = exp_data;
    held_err  = exp_err;

    @(negedge clk_sys);
    chk("resp_single", {31'h0, o_resp_valid}, 32'h0);
    chk("resp_data_hold", o_resp_data, held_data);
    chk("resp_err_hold", {31'h0, o_resp_err}, {31'h0, held_err});
  endtask

  initial begin
    i_reset     = 1'b1;
    i_req_valid = 1'b0;
    i_req_we    = 1'b0;
    i_req_addr  = '0;
    i_req_data  = '0;
    i_req_sel   = '0;
    slave_idle();
    repeat (3) @(negedge clk_sys);
    chk("rst_cyc", {31'h0, o_wb_cyc}, 32'h0);
    chk("rst_stb", {31'h0, o_wb_stb}, 32'h0);
    chk("rst_resp_valid", {31'h0, o_resp_valid}, 32'h0);
    chk("rst_resp_data", o_resp_data, 32'h0);
    chk("rst_wb_bus", {o_wb_we, o_wb_addr, o_wb_sel != 4'h0}, 32'h0);
    i_reset = 1'b0;
    @(negedge clk_sys);
    chk("rst_ready", {31'h0, o_req_ready}, 32'h1);

    // write, zero stall, ack in first WAIT_ACK cycle
    run_txn(1'b1, 30'h10, 32'h0000_1234, 4'hF, 0, 1, 1'b0, 1'b0, 1'b0, $urandom);
    // read with 3 stall cycles, ack 2 cycles after acceptance
    run_txn(1'b0, 30'h2A5, 32'h0, 4'hF, 3, 2, 1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF);
    // ERR together with ACK
    run_txn(1'b0, 30'h44, 32'h0, 4'h3, 0, 1, 1'b1, 1'b1, 1'b0, 32'h1111_2222);
    // dead slave
    run_txn(1'b0, 30'h3FF_FFFF, 32'h0, 4'hF, 0, 100, 1'b0, 1'b0, 1'b0, 32'h5555_AAAA);
    // ack exactly on the timeout cycle wins
    run_txn(1'b0, 30'h77, 32'h0, 4'hF, 2, TO - 3, 1'b0, 1'b0, 1'b0, 32'hCAFE_F00D);
    // ack one cycle too late
    run_txn(1'b0, 30'h78, 32'h0, 4'hF, 2, TO - 2, 1'b0, 1'b0, 1'b0, 32'hCAFE_F00E);
    // stalled past the timeout
    run_txn(1'b1, 30'h79, 32'h9999_0000, 4'hC, 12, 1, 1'b0, 1'b0, 1'b0, $urandom);
    // spurious ACK while stalled
    run_txn(1'b0, 30'h80, 32'h0, 4'hF, 2, 1, 1'b0, 1'b0, 1'b1, 32'h0BAD_0BAD);

    // reset while waiting for ACK
    i_req_valid = 1'b1;
    i_req_we    = 1'b0;
    i_req_addr  = 30'h123;
    i_req_sel   = 4'hF;
    @(negedge clk_sys);
    i_req_valid = 1'b0;
    @(negedge clk_sys);
    chk("mid_in_wait", {30'h0, o_wb_cyc, o_wb_stb}, 32'h2);
    i_reset = 1'b1;
    @(negedge clk_sys);
    i_reset = 1'b0;
    chk("mid_cyc", {31'h0, o_wb_cyc}, 32'h0);
    chk("mid_stb", {31'h0, o_wb_stb}, 32'h0);
    chk("mid_no_resp", {31'h0, o_resp_valid}, 32'h0);
    chk("mid_ready", {31'h0, o_req_ready}, 32'h1);
    i_wb_ack  = 1'b1;
    i_wb_data = 32'hFEED_FACE;
    @(negedge clk_sys);
    slave_idle();
    @(negedge clk_sys);
    chk("late_ack_ignored", {31'h0, o_resp_valid}, 32'h0);
    run_txn(1'b0, 30'h124, 32'h0, 4'hF, 1, 1, 1'b0, 1'b0, 1'b0, 32'h600D_D474);

    for (int i = 0; i < 40; i++) begin
      int wsel;
      wsel = $urandom_range(0, 9);
      run_txn(bit'($urandom_range(0, 1)), 30'($urandom), $urandom, 4'($urandom),
              $urandom_range(0, 9), (wsel == 0) ? 100 : $urandom_range(1, 8),
              ($urandom_range(0, 3) == 0), bit'($urandom_range(0, 1)),
              bit'($urandom_range(0, 1)), $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
